sum_driver: RTL and testbench

- Initiator side of the go_l/inA summation interface: generates a burst of operand values, drives them to a sumItUp-style accumulator, and waits for its done/sum response.
- Computes the expected sum itself and flags match, mismatch or timeout.
- Sits between the board-level start button (already synchronized and pulsed) and the adder; its result flags drive a green LED and its expected sum drives the seven-segment displays.

---
 rtl/sum_driver.sv | 106 ++++++++++
 tb/tb_sum_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sum_driver.sv
// sum_driver: drives an operand burst to a go_l/inA accumulator and checks its returned sum
module sum_driver #(
  parameter int unsigned LEN     = 8,
  parameter logic [7:0]  SEED    = 8'h01,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] fixed_val,
  input  logic       done,
  input  logic [7:0] result,
  output logic       go_l,
  output logic [7:0] value_out,
  output logic [7:0] expected_sum,
  output logic       busy,
  output logic       match,
  output logic       mismatch,
  output logic       timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GO, SEND, TERM, WAIT, REPORT} state_t;
  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d, fixed_q, fixed_d, sum_q, sum_d, count_q, count_d, cap_q, cap_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          match_q, match_d, mismatch_q, mismatch_d, timeout_q, timeout_d;
  logic [7:0]    operand;
  logic          expire;
  assign operand      = fixed_q != 8'h00 ? fixed_q : lfsr_q;
  assign expire       = state_q == WAIT && timer_q == TW'(TIMEOUT - 1);
  assign go_l         = state_q != GO;
  assign value_out    = (state_q == GO || state_q == SEND) ? operand : 8'h00;
  assign expected_sum = sum_q;
  assign busy         = state_q != IDLE;
  assign match        = match_q;
  assign mismatch     = mismatch_q;
  assign timeout      = timeout_q;
  // next-state: burst sequencing, running sum, response wait and flag update
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    fixed_d    = fixed_q;
    sum_d      = sum_q;
    count_d    = count_q;
    cap_d      = cap_q;
    timer_d    = timer_q;
    match_d    = match_q;
    mismatch_d = mismatch_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = GO;
        fixed_d    = fixed_val;
        sum_d      = 8'h00;
        count_d    = 8'h00;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        timeout_d  = 1'b0;
      end
      GO, SEND: begin
        sum_d   = sum_q + operand;
        count_d = count_q + 8'd1;
        lfsr_d  = fixed_q != 8'h00 ? lfsr_q : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d = count_d == 8'(LEN) ? TERM : SEND;
      end
      TERM, WAIT: begin
        timer_d   = state_q == TERM ? '0 : timer_q + 1'b1;
        cap_d     = done ? result : cap_q;
        timeout_d = !done && expire;
        state_d   = done ? REPORT : expire ? IDLE : WAIT;
      end
      REPORT: begin
        match_d    = cap_q == sum_q;
        mismatch_d = cap_q != sum_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      fixed_q    <= 8'h00;
      sum_q      <= 8'h00;
      count_q    <= 8'h00;
      cap_q      <= 8'h00;
      timer_q    <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      fixed_q    <= fixed_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      cap_q      <= cap_d;
      timer_q    <= timer_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end
endmodule

// File: tb/tb_sum_driver.sv
// tb_sum_driver: scoreboard bench with an accumulator responder and a reference operand model
module tb_sum_driver;
  localparam int LEN = 4;
  localparam logic [7:0] SEED = 8'h01;
  localparam int TIMEOUT = 16;
  logic ck = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] fixed_val = 8'h00;
  logic done, go_l, busy, match, mismatch, timeout;
  logic [7:0] result, value_out, expected_sum;
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_ops[$];
  logic [10:0] exp_res[$];
  logic [7:0] m_lfsr = SEED;
  int rsp_mode = 0;
  int rsp_delay = 0;

  sum_driver #(.LEN(LEN), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
    .ck(ck), .reset(reset), .start(start), .fixed_val(fixed_val), .done(done),
    .result(result), .go_l(go_l), .value_out(value_out), .expected_sum(expected_sum),
    .busy(busy), .match(match), .mismatch(mismatch), .timeout(timeout)
  );

  always #5 ck = ~ck;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // accumulator responder: sums the burst, answers after rsp_delay cycles (mode 1 corrupts, mode 2 never answers)
  initial begin
    logic [7:0] acc;
    bit coll, pend;
    int dly, hold;
    done = 1'b0; result = 8'h00; acc = 8'h00; coll = 0; pend = 0; dly = 0; hold = 0;
    forever begin
      @(negedge ck);
      if (reset) begin
        coll = 0; pend = 0; hold = 0; done = 1'b0;
      end else begin
        if (!go_l) begin acc = value_out; coll = 1; end
        else if (coll && value_out != 8'h00) acc = acc + value_out;
        else if (coll) begin coll = 0; if (rsp_mode != 2) begin pend = 1; dly = rsp_delay; end end
        if (hold > 0) begin hold--; if (hold == 0) done = 1'b0; end
        if (pend) begin
          if (dly == 0) begin done = 1'b1; result = acc ^ (rsp_mode == 1 ? 8'h01 : 8'h00); pend = 0; hold = 2; end
          else dly--;
        end
      end
    end
  end

  // monitor: pops expected operands as they appear and expected results when busy falls
  initial begin
    logic [8:0] e;
    logic [10:0] r;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge ck);
      if (!reset && (!go_l || value_out != 8'h00)) begin
        if (exp_ops.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_op got go_l=%b value=%h want none", go_l, value_out);
        end else begin
          e = exp_ops.pop_front();
          check("op_value", 32'(value_out), 32'(e[7:0]));
          check("op_go_l", 32'(go_l), 32'(e[8]));
        end
      end
      if (!reset && prev_busy === 1'b1 && busy === 1'b0) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_report got sum=%h want none", expected_sum);
        end else begin
          r = exp_res.pop_front();
          check("res_expected_sum", 32'(expected_sum), 32'(r[10:3]));
          check("res_match", 32'(match), 32'(r[2]));
          check("res_mismatch", 32'(mismatch), 32'(r[1]));
          check("res_timeout", 32'(timeout), 32'(r[0]));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic push_ops(input logic [7:0] fv, input int n, output logic [7:0] s);
    logic [7:0] op;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      op = fv != 8'h00 ? fv : m_lfsr;
      exp_ops.push_back({i != 0, op});
      s = s + op;
      if (fv == 8'h00) m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic run_burst(input logic [7:0] fv, input int mode, input int dly);
    logic [7:0] s;
    int n;
    push_ops(fv, LEN, s);
    exp_res.push_back({s, mode == 0, mode == 1, mode == 2});
    rsp_mode = mode; rsp_delay = dly; fixed_val = fv; start = 1'b1;
    @(negedge ck);
    start = 1'b0; fixed_val = 8'($urandom);
    check("busy_at_go", 32'(busy), 32'd1);
    check("flags_cleared", 32'({match, mismatch, timeout}), 32'd0);
    repeat (LEN) @(negedge ck);
    check("term_value", 32'(value_out), 32'd0);
    check("term_go_l", 32'(go_l), 32'd1);
    check("term_busy", 32'(busy), 32'd1);
    check("term_sum", 32'(expected_sum), 32'(s));
    n = 0;
    while (busy && n < 200) begin
      @(negedge ck);
      n++;
      start = (mode == 2 && n == 3);
    end
    start = 1'b0;
    check("cycles_term_to_idle", 32'(n), 32'(mode == 2 ? TIMEOUT + 1 : dly + 2));
  endtask

  initial begin
    logic [7:0] s;
    repeat (3) @(negedge ck);
    check("rst_go_l", 32'(go_l), 32'd1);
    check("rst_value", 32'(value_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(expected_sum), 32'd0);
    check("rst_flags", 32'({match, mismatch, timeout}), 32'd0);
    reset = 1'b0;
    @(negedge ck);
    run_burst(8'h00, 0, 0);
    run_burst(8'h00, 0, 3);
    run_burst(8'h80, 0, 2);
    run_burst(8'h00, 1, 1);
    repeat (5) @(negedge ck);
    check("mismatch_held", 32'(mismatch), 32'd1);
    check("match_held", 32'(match), 32'd0);
    run_burst(8'h00, 2, 0);
    repeat (3) @(negedge ck);
    check("timeout_held", 32'(timeout), 32'd1);
    push_ops(8'h00, 3, s);
    rsp_mode = 0; rsp_delay = 0; fixed_val = 8'h00; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (2) @(negedge ck);
    #1 reset = 1'b1;
    @(negedge ck);
    check("midrst_go_l", 32'(go_l), 32'd1);
    check("midrst_value", 32'(value_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(expected_sum), 32'd0);
    @(negedge ck);
    reset = 1'b0;
    m_lfsr = SEED;
    @(negedge ck);
    run_burst(8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      run_burst($urandom_range(0, 1) != 0 ? 8'($urandom_range(1, 255)) : 8'h00,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      repeat ($urandom_range(1, 3)) @(negedge ck);
    end
    repeat (10) @(negedge ck);
    check("ops_drained", 32'(exp_ops.size()), 32'd0);
    check("res_drained", 32'(exp_res.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
